instr_sequencer: RTL and testbench

//   Fetch/decode/execute controller for the 4-bit accumulator core. Drives the
//   16x12 program ROM address from an internal PC, latches the returned word

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/instr_decoder.sv | 23 ++
 rtl/instr_sequencer.sv | 94 +++++++++
 tb/tb_instr_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit accumulator core: opcodes, sequencer
// states and control-vector bit positions.
package cpu_pkg;

  localparam int WIDTH      = 12;
  localparam int ADDR_WIDTH = 4;
  localparam int OP_WIDTH   = 4;

  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_LDR = 4'hA;
  localparam logic [3:0] OP_STR = 4'hB;
  localparam logic [3:0] OP_NOP = 4'hC;
  localparam logic [3:0] OP_LDI = 4'hD;
  localparam logic [3:0] OP_RST = 4'hE;

  typedef enum logic [1:0] {
    S_FETCH  = 2'b00,
    S_DECODE = 2'b01,
    S_EXEC   = 2'b10,
    S_WAIT   = 2'b11
  } state_t;

  localparam int C_LDI  = 0;
  localparam int C_INC  = 1;
  localparam int C_ADD  = 2;
  localparam int C_LDR  = 3;
  localparam int C_STA  = 4;
  localparam int C_ILL  = 5;
  localparam int C_RST  = 6;
  localparam int CTRL_W = 7;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder; shared with the disassembler/trace monitor.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [3:0]        i_op,
  output logic [CTRL_W-1:0] o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_op)
      OP_LDI:  o_ctrl[C_LDI] = 1'b1;
      OP_INC:  o_ctrl[C_INC] = 1'b1;
      OP_ADD:  o_ctrl[C_ADD] = 1'b1;
      OP_LDR:  o_ctrl[C_LDR] = 1'b1;
      OP_STR:  o_ctrl[C_STA] = 1'b1;
      OP_NOP:  o_ctrl        = '0;
      OP_RST:  o_ctrl[C_RST] = 1'b1;
      default: o_ctrl[C_ILL] = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller: PC drives the ROM, IR latches the word,
// EXEC issues one-cycle strobes. SINGLE_STEP_EN adds STEP and a WAIT state.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int ADDR_WIDTH = 4,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
`ifdef SINGLE_STEP_EN
  input  logic                  STEP,
`endif
  input  logic [WIDTH-1:0]      ROM_DATA,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  output logic [3:0]            IMM,
  output logic                  EXEC_A_LDI,
  output logic                  EXEC_A_INC,
  output logic                  EXEC_A_ADD,
  output logic                  EXEC_A_LDR,
  output logic                  EXEC_R_STA,
  output logic                  ILLEGAL,
  output logic [1:0]            STATE
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [WIDTH-1:0]      r_ir;
  logic [CTRL_W-1:0]     r_ctrl;
  logic [3:0]            r_imm;
  logic [CTRL_W-1:0]     w_dec;
  logic                  w_unused;

  // Low nibble of the instruction word is reserved.
  assign w_unused = ^{ROM_DATA[3:0], r_ir[3:0]};

  instr_decoder u_dec (
    .i_op   (r_ir[WIDTH-1 -: OP_WIDTH]),
    .o_ctrl (w_dec)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_ctrl  <= '0;
      r_imm   <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (EN) begin
            r_ir    <= ROM_DATA;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_ctrl  <= w_dec;
          r_imm   <= w_dec[C_LDI] ? r_ir[WIDTH-OP_WIDTH-1 -: 4] : 4'h0;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_ctrl <= '0;
          r_imm  <= '0;
          r_pc   <= r_ctrl[C_RST] ? '0 : r_pc + 1'b1;
`ifdef SINGLE_STEP_EN
          r_state <= S_WAIT;
`else
          r_state <= S_FETCH;
`endif
        end
`ifdef SINGLE_STEP_EN
        S_WAIT: begin
          if (STEP) r_state <= S_FETCH;
        end
`endif
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign ROM_ADDR   = r_pc;
  assign IMM        = r_imm;
  assign EXEC_A_LDI = r_ctrl[C_LDI];
  assign EXEC_A_INC = r_ctrl[C_INC];
  assign EXEC_A_ADD = r_ctrl[C_ADD];
  assign EXEC_A_LDR = r_ctrl[C_LDR];
  assign EXEC_R_STA = r_ctrl[C_STA];
  assign ILLEGAL    = r_ctrl[C_ILL];
  assign STATE      = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a ROM and reference A/R datapath.
module tb_instr_sequencer;

`ifdef SINGLE_STEP_EN
  localparam int CYC = 4;
`else
  localparam int CYC = 3;
`endif
  localparam int W = CYC - 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN  = 1'b1;
`ifdef SINGLE_STEP_EN
  logic        STEP = 1'b1;
`endif
  logic [11:0] ROM_DATA;
  logic [3:0]  ROM_ADDR;
  logic [3:0]  IMM;
  logic        EXEC_A_LDI, EXEC_A_INC, EXEC_A_ADD, EXEC_A_LDR, EXEC_R_STA;
  logic        ILLEGAL;
  logic [1:0]  STATE;

  logic [11:0] rom [16];
  assign ROM_DATA = rom[ROM_ADDR];

  instr_sequencer dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
`ifdef SINGLE_STEP_EN
    .STEP       (STEP),
`endif
    .ROM_DATA   (ROM_DATA),
    .ROM_ADDR   (ROM_ADDR),
    .IMM        (IMM),
    .EXEC_A_LDI (EXEC_A_LDI),
    .EXEC_A_INC (EXEC_A_INC),
    .EXEC_A_ADD (EXEC_A_ADD),
    .EXEC_A_LDR (EXEC_A_LDR),
    .EXEC_R_STA (EXEC_R_STA),
    .ILLEGAL    (ILLEGAL),
    .STATE      (STATE)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe log entries: {code, imm}; LDI=1, INC=2, ADD=3, LDR=4, STA=5.
  logic [7:0] log_q [$];
  logic [3:0] m_a, m_r;
  int         n_multi = 0;
  int         mon_k;

  always @(negedge CLK) begin
    if (RST) begin
      m_a = 4'h0;
      m_r = 4'h0;
    end else begin
      mon_k = int'(EXEC_A_LDI) + int'(EXEC_A_INC) + int'(EXEC_A_ADD)
            + int'(EXEC_A_LDR) + int'(EXEC_R_STA);
      if (mon_k > 1) n_multi++;
      if (EXEC_A_LDI) begin log_q.push_back({4'h1, IMM}); m_a = IMM;       end
      if (EXEC_A_INC) begin log_q.push_back(8'h20);       m_a = m_a + 4'h1; end
      if (EXEC_A_ADD) begin log_q.push_back(8'h30);       m_a = m_a + m_r;  end
      if (EXEC_A_LDR) begin log_q.push_back(8'h40);       m_a = m_r;        end
      if (EXEC_R_STA) begin log_q.push_back(8'h50);       m_r = m_a;        end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [7:0] log_at(input int i);
    return (i < log_q.size()) ? log_q[i] : 8'hFF;
  endfunction

  logic [7:0] exp_demo [13] = '{8'h12, 8'h20, 8'h20, 8'h50, 8'h20, 8'h20, 8'h30,
                                8'h20, 8'h20, 8'h40, 8'h30, 8'h20, 8'h20};
  int stuck;

  initial begin
    rom = '{12'hC00, 12'hD20, 12'h900, 12'h900, 12'hB00, 12'h900, 12'h900, 12'h500,
            12'h900, 12'h900, 12'hA00, 12'h500, 12'h900, 12'h900, 12'hE00, 12'hC00};

    // Reset state
    ticks(2);
    chk("rst_addr",    32'(ROM_ADDR), 32'h0);
    chk("rst_state",   32'(STATE), 32'h0);
    chk("rst_strobes", 32'({EXEC_A_LDI, EXEC_A_INC, EXEC_A_ADD, EXEC_A_LDR, EXEC_R_STA, ILLEGAL}), 32'h0);
    chk("rst_imm",     32'(IMM), 32'h0);
    RST = 1'b0;
    log_q.delete();

    // Three cycles per instruction
    ticks(3);
    chk("t1_pc1", 32'(ROM_ADDR), 32'h1);
    ticks(CYC);
    chk("t1_pc2", 32'(ROM_ADDR), 32'h2);

    // Demo program up to and including the rst word
    ticks(13 * CYC);
    chk("t2_pc_wrap", 32'(ROM_ADDR), 32'h0);
    chk("t2_state",   32'(STATE), (CYC == 4) ? 32'h3 : 32'h0);
    chk("t2_nstrobe", 32'(log_q.size()), 32'd13);
    for (int i = 0; i < 13; i++) chk($sformatf("t2_strobe%0d", i), 32'(log_at(i)), 32'(exp_demo[i]));
    chk("t2_model_a", 32'(m_a), 32'hA);
    chk("t2_model_r", 32'(m_r), 32'h4);
    chk("t2_onehot",  32'(n_multi), 32'h0);

    // EN low while in FETCH at PC=5
    ticks(W + 5 * CYC);
    chk("t3_at5", 32'(ROM_ADDR), 32'h5);
    EN = 1'b0;
    log_q.delete();
    stuck = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (STATE != 2'b00 || ROM_ADDR != 4'h5) stuck++;
    end
    chk("t3_hold",    32'(stuck), 32'h0);
    chk("t3_nostrb",  32'(log_q.size()), 32'h0);
    EN = 1'b1;
    ticks(3);
    chk("t3_resume",  32'(log_at(0)), 32'h20);
    chk("t3_pc6",     32'(ROM_ADDR), 32'h6);

    // Undefined opcode at PC=F
    rom[14] = 12'hC00;
    rom[15] = 12'h300;
    ticks(W + 9 * CYC);
    chk("t4_atF", 32'(ROM_ADDR), 32'hF);
    log_q.delete();
    tick();
    chk("t4_ill_dec", 32'(ILLEGAL), 32'h0);
    tick();
    chk("t4_ill_exe", 32'(ILLEGAL), 32'h1);
    chk("t4_nostrb",  32'({EXEC_A_LDI, EXEC_A_INC, EXEC_A_ADD, EXEC_A_LDR, EXEC_R_STA}), 32'h0);
    tick();
    chk("t4_ill_clr", 32'(ILLEGAL), 32'h0);
    chk("t4_wrap",    32'(ROM_ADDR), 32'h0);
    chk("t4_nolog",   32'(log_q.size()), 32'h0);

    // Reset in the middle of EXEC of add at PC=7
    rom[14] = 12'hE00;
    rom[15] = 12'hC00;
    ticks(W + 7 * CYC);
    chk("t5_at7", 32'(ROM_ADDR), 32'h7);
    ticks(2);
    chk("t5_add", 32'(EXEC_A_ADD), 32'h1);
    #2 RST = 1'b1;
    #1;
    chk("t5_add_drop", 32'(EXEC_A_ADD), 32'h0);
    chk("t5_pc0",      32'(ROM_ADDR), 32'h0);
    chk("t5_state",    32'(STATE), 32'h0);
    tick();
    RST = 1'b0;
    tick();
    chk("t5_restart",  32'(STATE), 32'h1);

`ifdef SINGLE_STEP_EN
    // Single-step: one instruction per STEP pulse
    STEP = 1'b0;
    RST  = 1'b1;
    tick();
    RST = 1'b0;
    log_q.delete();
    ticks(3);
    chk("t6_wait",   32'(STATE), 32'h3);
    chk("t6_pc1",    32'(ROM_ADDR), 32'h1);
    ticks(5);
    chk("t6_hold",   32'(STATE), 32'h3);
    chk("t6_nolog",  32'(log_q.size()), 32'h0);
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    ticks(3);
    chk("t6_wait2",  32'(STATE), 32'h3);
    chk("t6_n1",     32'(log_q.size()), 32'h1);
    chk("t6_ldi",    32'(log_at(0)), 32'h12);
    ticks(4);
    chk("t6_n1hold", 32'(log_q.size()), 32'h1);
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    ticks(3);
    chk("t6_n2",     32'(log_q.size()), 32'h2);
    chk("t6_inc",    32'(log_at(1)), 32'h20);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
